// File: rtl/riscv_mem_ctrl.sv
// riscv_mem_ctrl: arbiter and byte sequencer in front of a byte-wide BRAM.
// Two requesters share the BRAM: instruction fetch (if_*, always a word load)
// and load/store data (d_*, RISC-V funct3 sizing). A request is turned into
// 1, 2 or 4 little-endian single-byte BRAM accesses. Loads are sign/zero
// extended. A request that is illegal, misaligned or out of range is answered
// with err=1 and never touches the BRAM.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request (held until if_ready)
//   if_ready/if_rdata/if_err  one-cycle fetch completion with result
//   d_req/d_we/d_funct3/d_addr/d_wdata  data request (held until d_ready)
//   d_ready/d_rdata/d_err     one-cycle data completion with result
//   bram_write_en/bram_waddr/bram_wdata/bram_raddr/bram_dout  BRAM side
//   busy                      controller is not idle
module riscv_mem_ctrl #(
    parameter int ADDR_LENGTH = 32,
    parameter int NUM_MEM     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [ADDR_LENGTH-1:0] if_addr,
    output logic                   if_ready,
    output logic [31:0]            if_rdata,
    output logic                   if_err,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [2:0]             d_funct3,
    input  logic [ADDR_LENGTH-1:0] d_addr,
    input  logic [31:0]            d_wdata,
    output logic                   d_ready,
    output logic [31:0]            d_rdata,
    output logic                   d_err,
    output logic                   bram_write_en,
    output logic [ADDR_LENGTH-1:0] bram_waddr,
    output logic [7:0]             bram_wdata,
    output logic [ADDR_LENGTH-1:0] bram_raddr,
    input  logic [7:0]             bram_dout,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

    // One bit wider than an address so addr+N-1 cannot wrap.
    localparam logic [ADDR_LENGTH:0] NUM_MEM_W = (ADDR_LENGTH+1)'(NUM_MEM);

    state_t                 state_r, state_next_s;
    logic [1:0]             cnt_r, last_r;
    logic [ADDR_LENGTH-1:0] addr_r;
    logic                   we_r, port_r, last_grant_r;   // port: 1 = D, 0 = IF
    logic [2:0]             funct3_r;
    logic [31:0]            wdata_r, result_r, result_next_s;
    logic                   if_ready_r, if_err_r, d_ready_r, d_err_r;
    logic [31:0]            if_rdata_r, d_rdata_r;

    logic                   grant_s, grant_d_s, bad_s, xfer_s;
    logic [ADDR_LENGTH-1:0] g_addr_s, cur_addr_s;
    logic                   g_we_s;
    logic [2:0]             g_funct3_s;
    logic [31:0]            g_wdata_s;
    logic [1:0]             g_last_s;
    logic [4:0]             lane_s;

    // Index of the last byte of an access: 0, 1 or 3 for byte/half/word.
    function automatic logic [1:0] last_index(input logic [1:0] sz);
        logic [1:0] r;
        case (sz)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    // Legality, alignment and range check of a request at grant time.
    function automatic logic req_error(input logic we, input logic [2:0] f3,
                                       input logic [ADDR_LENGTH-1:0] addr);
        logic                 bad;
        logic [1:0]           last;
        logic [ADDR_LENGTH:0] end_addr;
        last     = last_index(f3[1:0]);
        end_addr = {1'b0, addr} + {{(ADDR_LENGTH-1){1'b0}}, last};
        if (we) begin
            bad = (f3 > 3'd2);
        end else begin
            bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        if ((last == 2'd1) && addr[0]) begin
            bad = 1'b1;
        end else if ((last == 2'd3) && (addr[1:0] != 2'b00)) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        if (end_addr >= NUM_MEM_W) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    // RISC-V load extension of the assembled little-endian bytes.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] r;
        case (f3)
            3'd0:    r = {{24{raw[7]}}, raw[7:0]};
            3'd1:    r = {{16{raw[15]}}, raw[15:0]};
            3'd4:    r = {24'd0, raw[7:0]};
            3'd5:    r = {16'd0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign xfer_s     = (state_r == XFER);
    assign lane_s     = {cnt_r, 3'b000};
    assign cur_addr_s = addr_r + {{(ADDR_LENGTH-2){1'b0}}, cnt_r};

    // Arbitration, request selection, error check and next-state decode.
    always_comb begin
        state_next_s  = state_r;
        grant_s       = 1'b0;
        grant_d_s     = 1'b0;
        g_addr_s      = if_addr;
        g_we_s        = 1'b0;
        g_funct3_s    = 3'd2;
        g_wdata_s     = 32'd0;
        g_last_s      = 2'd3;
        bad_s         = 1'b0;
        result_next_s = result_r;
        result_next_s[lane_s +: 8] = bram_dout;
        case (state_r)
            IDLE: begin
                if (if_req && d_req) begin
                    grant_s   = 1'b1;
                    grant_d_s = ~last_grant_r;
                end else if (d_req) begin
                    grant_s   = 1'b1;
                    grant_d_s = 1'b1;
                end else if (if_req) begin
                    grant_s   = 1'b1;
                    grant_d_s = 1'b0;
                end else begin
                    grant_s   = 1'b0;
                    grant_d_s = 1'b0;
                end
                if (grant_d_s) begin
                    g_addr_s   = d_addr;
                    g_we_s     = d_we;
                    g_funct3_s = d_funct3;
                    g_wdata_s  = d_wdata;
                end else begin
                    g_addr_s   = if_addr;
                    g_we_s     = 1'b0;
                    g_funct3_s = 3'd2;
                    g_wdata_s  = 32'd0;
                end
                g_last_s = last_index(g_funct3_s[1:0]);
                bad_s    = req_error(g_we_s, g_funct3_s, g_addr_s);
                if (grant_s) begin
                    state_next_s = bad_s ? DONE : XFER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            XFER: begin
                if (cnt_r == last_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = XFER;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, latched request, byte assembly and registered completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 2'd0;
            last_r       <= 2'd0;
            addr_r       <= '0;
            we_r         <= 1'b0;
            port_r       <= 1'b0;
            last_grant_r <= 1'b0;
            funct3_r     <= 3'd0;
            wdata_r      <= 32'd0;
            result_r     <= 32'd0;
            if_ready_r   <= 1'b0;
            if_err_r     <= 1'b0;
            if_rdata_r   <= 32'd0;
            d_ready_r    <= 1'b0;
            d_err_r      <= 1'b0;
            d_rdata_r    <= 32'd0;
        end else begin
            state_r    <= state_next_s;
            // Completion outputs are single-cycle: cleared unless set below.
            if_ready_r <= 1'b0;
            if_err_r   <= 1'b0;
            if_rdata_r <= 32'd0;
            d_ready_r  <= 1'b0;
            d_err_r    <= 1'b0;
            d_rdata_r  <= 32'd0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        last_grant_r <= grant_d_s;
                        port_r       <= grant_d_s;
                        addr_r       <= g_addr_s;
                        we_r         <= g_we_s;
                        funct3_r     <= g_funct3_s;
                        wdata_r      <= g_wdata_s;
                        last_r       <= g_last_s;
                        cnt_r        <= 2'd0;
                        result_r     <= 32'd0;
                        if (bad_s) begin
                            if (grant_d_s) begin
                                d_ready_r <= 1'b1;
                                d_err_r   <= 1'b1;
                            end else begin
                                if_ready_r <= 1'b1;
                                if_err_r   <= 1'b1;
                            end
                        end
                    end
                end
                XFER: begin
                    cnt_r <= cnt_r + 2'd1;
                    if (!we_r) begin
                        result_r <= result_next_s;
                    end
                    // The final byte is folded in directly from bram_dout.
                    if (cnt_r == last_r) begin
                        if (port_r) begin
                            d_ready_r <= 1'b1;
                            d_rdata_r <= we_r ? 32'd0 : load_extend(funct3_r, result_next_s);
                        end else begin
                            if_ready_r <= 1'b1;
                            if_rdata_r <= load_extend(funct3_r, result_next_s);
                        end
                    end
                end
                DONE:    cnt_r <= 2'd0;
                default: cnt_r <= 2'd0;
            endcase
        end
    end

    assign if_ready = if_ready_r;
    assign if_rdata = if_rdata_r;
    assign if_err   = if_err_r;
    assign d_ready  = d_ready_r;
    assign d_rdata  = d_rdata_r;
    assign d_err    = d_err_r;
    assign busy     = (state_r != IDLE);

    // Write enable is gated by rst so an aborting reset cycle writes nothing.
    assign bram_write_en = xfer_s && we_r && !rst;
    assign bram_waddr    = (xfer_s && we_r) ? cur_addr_s : '0;
    assign bram_wdata    = (xfer_s && we_r) ? wdata_r[lane_s +: 8] : 8'd0;
    assign bram_raddr    = xfer_s ? cur_addr_s : '0;

endmodule

// File: tb/tb_riscv_mem_ctrl.sv
// Directed self-checking bench for riscv_mem_ctrl with a small BRAM model.
module tb_riscv_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ready, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [2:0]  d_funct3 = 3'd0;
    logic [31:0] d_addr = 32'd0, d_wdata = 32'd0;
    logic        d_ready, d_err;
    logic [31:0] d_rdata;
    logic        bram_write_en;
    logic [31:0] bram_waddr, bram_raddr;
    logic [7:0]  bram_wdata, bram_dout;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic mem_clr = 1'b1;
    logic [7:0] mem [0:15];
    logic [31:0] wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    int          wr_cyc_q  [$];

    riscv_mem_ctrl #(.ADDR_LENGTH(32), .NUM_MEM(10)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .bram_write_en(bram_write_en), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
        .bram_raddr(bram_raddr), .bram_dout(bram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    assign bram_dout = (bram_raddr < 32'd16) ? mem[bram_raddr[3:0]] : 8'h00;

    // BRAM model with a write log.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        end else if (bram_write_en) begin
            mem[bram_waddr[3:0]] <= bram_wdata;
            wr_addr_q.push_back(bram_waddr);
            wr_data_q.push_back(bram_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one data request from an IDLE negedge; returns result and latency.
    task automatic d_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
        lat = 0; rd = 32'hxxxxxxxx; er = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (d_ready) begin
                lat = k; rd = d_rdata; er = d_err;
                break;
            end
        end
        d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
        @(negedge clk);
        check("d_ready_single_pulse", {31'd0, d_ready}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, base;
        int          pulses [$];
        logic        prev_rdy;
        int          doubles, last_k;

        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        do_reset();

        // Reset state.
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ready", {30'd0, if_ready, d_ready}, 32'd0);
        check("reset_err", {30'd0, if_err, d_err}, 32'd0);
        check("reset_d_rdata", d_rdata, 32'd0);
        check("reset_if_rdata", if_rdata, 32'd0);
        check("reset_we", {31'd0, bram_write_en}, 32'd0);
        check("reset_raddr", bram_raddr, 32'd0);
        check("reset_waddr", bram_waddr, 32'd0);

        // SW 4 0xDEADBEEF.
        d_txn(1'b1, 3'd2, 32'd4, 32'hDEADBEEF, rd, er, lat);
        check("sw_latency", lat, 32'd5);
        check("sw_err", {31'd0, er}, 32'd0);
        check("sw_rdata", rd, 32'd0);
        check("sw_nwrites", wr_addr_q.size(), 32'd4);
        if (wr_addr_q.size() == 4) begin
            check("sw_addr0", wr_addr_q[0], 32'd4);
            check("sw_addr3", wr_addr_q[3], 32'd7);
            check("sw_data", {wr_data_q[3], wr_data_q[2], wr_data_q[1], wr_data_q[0]}, 32'hDEADBEEF);
            check("sw_consecutive", wr_cyc_q[3] - wr_cyc_q[0], 32'd3);
        end

        // Loads of the stored word with each extension.
        d_txn(1'b0, 3'd2, 32'd4, 32'd0, rd, er, lat);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_latency", lat, 32'd5);
        d_txn(1'b0, 3'd0, 32'd7, 32'd0, rd, er, lat);
        check("lb_rdata", rd, 32'hFFFFFFDE);
        check("lb_latency", lat, 32'd2);
        d_txn(1'b0, 3'd4, 32'd7, 32'd0, rd, er, lat);
        check("lbu_rdata", rd, 32'h000000DE);
        d_txn(1'b0, 3'd1, 32'd6, 32'd0, rd, er, lat);
        check("lh_rdata", rd, 32'hFFFFDEAD);
        check("lh_latency", lat, 32'd3);
        d_txn(1'b0, 3'd5, 32'd6, 32'd0, rd, er, lat);
        check("lhu_rdata", rd, 32'h0000DEAD);
        check("lhu_err", {31'd0, er}, 32'd0);

        // Error requests: misaligned word, misaligned half store, out of range, bad funct3.
        base = wr_addr_q.size();
        d_txn(1'b0, 3'd2, 32'd2, 32'd0, rd, er, lat);
        check("err_lw2", {lat[7:0], 23'd0, er}, {8'd1, 23'd0, 1'b1});
        check("err_lw2_rdata", rd, 32'd0);
        d_txn(1'b1, 3'd1, 32'd5, 32'h1234, rd, er, lat);
        check("err_sh5", {lat[7:0], 23'd0, er}, {8'd1, 23'd0, 1'b1});
        d_txn(1'b0, 3'd2, 32'd8, 32'd0, rd, er, lat);
        check("err_lw8", {lat[7:0], 23'd0, er}, {8'd1, 23'd0, 1'b1});
        d_txn(1'b0, 3'd3, 32'd0, 32'd0, rd, er, lat);
        check("err_f3_3", {lat[7:0], 23'd0, er}, {8'd1, 23'd0, 1'b1});
        d_txn(1'b1, 3'd0, 32'd10, 32'h55, rd, er, lat);
        check("err_sb10", {lat[7:0], 23'd0, er}, {8'd1, 23'd0, 1'b1});
        check("err_no_writes", wr_addr_q.size() - base, 32'd0);

        // Arbitration: both requests right after reset, held continuously.
        do_reset();
        if_req = 1'b1; if_addr = 32'd4;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'd2; d_addr = 32'd4;
        prev_rdy = 1'b0; doubles = 0; last_k = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if ((if_ready || d_ready) && prev_rdy) doubles++;
            if (if_ready && d_ready) doubles++;
            if (d_ready) begin
                pulses.push_back(1);
                check("arb_d_rdata", d_rdata, 32'hDEADBEEF);
            end
            if (if_ready) begin
                pulses.push_back(0);
                check("arb_if_rdata", if_rdata, 32'hDEADBEEF);
                check("arb_if_err", {31'd0, if_err}, 32'd0);
            end
            if (pulses.size() == 1 && (if_ready || d_ready)) check("arb_first_latency", k, 32'd5);
            prev_rdy = if_ready || d_ready;
            if (pulses.size() >= 4) begin
                last_k = k;
                break;
            end
        end
        if_req = 1'b0; d_req = 1'b0; d_funct3 = 3'd0; d_addr = 32'd0; if_addr = 32'd0;
        check("arb_pulses", pulses.size(), 32'd4);
        if (pulses.size() == 4) begin
            check("arb_order", {pulses[0][7:0], pulses[1][7:0], pulses[2][7:0], pulses[3][7:0]},
                  32'h01000100);
        end
        check("arb_last_cycle", last_k, 32'd23);
        check("arb_no_double", doubles, 32'd0);
        @(negedge clk);

        // Reset in the second XFER cycle of SW 0.
        base = wr_addr_q.size();
        d_req = 1'b1; d_we = 1'b1; d_funct3 = 3'd2; d_addr = 32'd0; d_wdata = 32'h44332211;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        d_req = 1'b0; d_we = 1'b0; d_funct3 = 3'd0; d_wdata = 32'd0;
        #1;
        check("midrst_we_gated", {31'd0, bram_write_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_outs", {28'd0, if_ready, d_ready, d_err, bram_write_en}, 32'd0);
        check("midrst_addrs", bram_raddr | bram_waddr | {24'd0, bram_wdata} | d_rdata, 32'd0);
        check("midrst_nwrites", wr_addr_q.size() - base, 32'd1);
        check("midrst_mem", {16'd0, mem[1], mem[0]}, 32'h00000011);

        // Normal operation after the abort.
        d_txn(1'b1, 3'd0, 32'd1, 32'h00000077, rd, er, lat);
        check("post_sb_latency", lat, 32'd2);
        d_txn(1'b0, 3'd2, 32'd0, 32'd0, rd, er, lat);
        check("post_lw_rdata", rd, 32'h00007711);
        check("post_lw_err", {31'd0, er}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
